// File: rtl/compare_set_if.sv
// Request/response bundle for compare_set_unit. The master drives the operands and start.
// The slave returns busy/done and the registered compare outcome.
interface compare_set_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             flag;
    logic [WIDTH-1:0] result;

    // Handshake: start is looked at only while busy=0 and is accepted on that clock edge.
    // done pulses for exactly one cycle when flag/result take a new value.
    modport master (output start, op, x, y, input busy, done, flag, result);
    modport slave  (input start, op, x, y, output busy, done, flag, result);
endinterface

// File: rtl/compare_set_unit.sv
// Multi-cycle comparator: examines CHUNK bits per clock, MSB chunk first, and registers a set-style flag.
// Signed orders reuse the unsigned chunk compare by flipping both sign bits when the operands are latched.
module compare_set_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int MASK  = 1
) (
    input logic          clk,
    input logic          rst,
    compare_set_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N + 1);
    localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] xr, yr;
    logic [1:0]       opr;
    logic [CW-1:0]    cnt;
    logic             decided, lt, gt;
    logic             flag_q, done_q;
    logic [WIDTH-1:0] result_q;

    logic [CHUNK-1:0] xc, yc;
    logic             decided_n, lt_n, gt_n;
    logic             last, accept, flag_n;
    logic [WIDTH-1:0] sign_fix, result_n;

    always_comb begin
        state_n   = state;
        xc        = xr[WIDTH-1 -: CHUNK];
        yc        = yr[WIDTH-1 -: CHUNK];
        decided_n = decided;
        lt_n      = lt;
        gt_n      = gt;
        // The first differing chunk from the top settles the order for good.
        if (!decided && (xc != yc)) begin
            decided_n = 1'b1;
            lt_n      = (xc < yc);
            gt_n      = !(xc < yc);
        end
        last   = (state == RUN) && (cnt == CW'(1));
        accept = (state == IDLE) && bus.start;
        case (opr)
            2'b00, 2'b01: flag_n = lt_n;
            2'b10:        flag_n = !lt_n && !gt_n;
            default:      flag_n = !gt_n;
        endcase
        result_n = (MASK != 0) ? {WIDTH{flag_n}} : {{(WIDTH-1){1'b0}}, flag_n};
        sign_fix = ((bus.op == 2'b00) || (bus.op == 2'b11)) ? SIGN_BIT : '0;
        case (state)
            IDLE:    if (bus.start) state_n = RUN;
            RUN:     if (last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xr       <= '0;
            yr       <= '0;
            opr      <= '0;
            cnt      <= '0;
            decided  <= 1'b0;
            lt       <= 1'b0;
            gt       <= 1'b0;
            flag_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                xr      <= bus.x ^ sign_fix;
                yr      <= bus.y ^ sign_fix;
                opr     <= bus.op;
                cnt     <= CW'(N);
                decided <= 1'b0;
                lt      <= 1'b0;
                gt      <= 1'b0;
            end else if (state == RUN) begin
                xr      <= xr << CHUNK;
                yr      <= yr << CHUNK;
                cnt     <= cnt - CW'(1);
                decided <= decided_n;
                lt      <= lt_n;
                gt      <= gt_n;
                if (last) begin
                    flag_q   <= flag_n;
                    result_q <= result_n;
                end
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = done_q;
    assign bus.flag   = flag_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_compare_set_unit.sv
// Bench for compare_set_unit: a 16/4/MASK=1 instance and a 16/16/MASK=0 instance sharing clock and reset.
// Directed table, randomized ops against a plain-arithmetic reference, and handshake/reset sequences.
module tb_compare_set_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    compare_set_if #(.WIDTH(16)) if_a ();
    compare_set_if #(.WIDTH(16)) if_b ();

    compare_set_unit #(.WIDTH(16), .CHUNK(4),  .MASK(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    compare_set_unit #(.WIDTH(16), .CHUNK(16), .MASK(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        bit          exp_flag;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit ref_flag(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'b00:   return sa < sb;
            2'b01:   return a < b;
            2'b10:   return a == b;
            default: return sa <= sb;
        endcase
    endfunction

    function automatic logic [15:0] ref_result(input bit sel, input bit f);
        return sel ? {15'b0, f} : {16{f}};
    endfunction

    task automatic drive(input bit sel, input bit s, input logic [1:0] op, input logic [15:0] xa, input logic [15:0] ya);
        if (sel) begin
            if_b.start = s; if_b.op = op; if_b.x = xa; if_b.y = ya;
        end else begin
            if_a.start = s; if_a.op = op; if_a.x = xa; if_a.y = ya;
        end
    endtask

    function automatic bit get_busy(input bit sel);
        return sel ? if_b.busy : if_a.busy;
    endfunction
    function automatic bit get_done(input bit sel);
        return sel ? if_b.done : if_a.done;
    endfunction
    function automatic bit get_flag(input bit sel);
        return sel ? if_b.flag : if_a.flag;
    endfunction
    function automatic logic [15:0] get_result(input bit sel);
        return sel ? if_b.result : if_a.result;
    endfunction

    // One full operation: start, count cycles to done, verify outputs held while busy.
    task automatic run_op(input bit sel, input logic [1:0] op, input logic [15:0] xa, input logic [15:0] ya,
                          input string name);
        bit          ef, dn, moved, gap;
        logic [15:0] held_res;
        bit          held_flag;
        int          lat, exp_lat;
        ef      = ref_flag(op, xa, ya);
        exp_lat = sel ? 1 : 4;
        @(negedge clk);
        drive(sel, 1'b1, op, xa, ya);
        @(posedge clk); #1;
        drive(sel, 1'b0, op, xa, ya);
        check({name, " busy_after_start"}, 32'(get_busy(sel)), 32'd1);
        held_res  = get_result(sel);
        held_flag = get_flag(sel);
        moved = 1'b0; gap = 1'b0; dn = 1'b0; lat = 0;
        while (!dn && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            dn = get_done(sel);
            if (!dn && (get_result(sel) !== held_res || get_flag(sel) !== held_flag)) moved = 1'b1;
            if (!dn && !get_busy(sel)) gap = 1'b1;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " held_while_busy"}, 32'({moved, gap}), 32'd0);
        check({name, " flag"}, 32'(get_flag(sel)), 32'(ef));
        check({name, " result"}, 32'(get_result(sel)), 32'(ref_result(sel, ef)));
        check({name, " busy_at_done"}, 32'(get_busy(sel)), 32'd0);
        @(posedge clk); #1;
        check({name, " done_one_cycle"}, 32'(get_done(sel)), 32'd0);
    endtask

    initial begin
        int          ndone, dlat, lat;
        logic [1:0]  rop;
        logic [15:0] rx, ry;
        int          mode;
        logic [15:0] edge_vals[5];

        edge_vals[0] = 16'h0000; edge_vals[1] = 16'h0001; edge_vals[2] = 16'h7FFF;
        edge_vals[3] = 16'h8000; edge_vals[4] = 16'hFFFF;

        vecs.push_back('{"slt_neg1_1",     2'b00, 16'hFFFF, 16'h0001, 1'b1});
        vecs.push_back('{"sltu_ffff_1",    2'b01, 16'hFFFF, 16'h0001, 1'b0});
        vecs.push_back('{"seq_8000",       2'b10, 16'h8000, 16'h8000, 1'b1});
        vecs.push_back('{"sle_8000",       2'b11, 16'h8000, 16'h8000, 1'b1});
        vecs.push_back('{"slt_8000_eq",    2'b00, 16'h8000, 16'h8000, 1'b0});
        vecs.push_back('{"slt_min_max",    2'b00, 16'h8000, 16'h7FFF, 1'b1});
        vecs.push_back('{"sltu_min_max",   2'b01, 16'h8000, 16'h7FFF, 1'b0});
        vecs.push_back('{"sltu_lsb_chunk", 2'b01, 16'h1230, 16'h1231, 1'b1});
        vecs.push_back('{"sltu_msb_chunk", 2'b01, 16'h1FFF, 16'h2000, 1'b1});
        vecs.push_back('{"slt_msb_chunk",  2'b00, 16'h1FFF, 16'h2000, 1'b1});
        vecs.push_back('{"sle_gt",         2'b11, 16'h0002, 16'hFFFF, 1'b0});
        vecs.push_back('{"seq_diff_lsb",   2'b10, 16'hABCD, 16'hABCC, 1'b0});

        drive(1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 2'b00, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   32'(if_a.busy),   32'd0);
        check("reset done",   32'(if_a.done),   32'd0);
        check("reset flag",   32'(if_a.flag),   32'd0);
        check("reset result", 32'(if_a.result), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table on the chunked instance.
        for (int i = 0; i < vecs.size(); i++) begin
            check({vecs[i].name, " table_expect"}, 32'(ref_flag(vecs[i].op, vecs[i].x, vecs[i].y)),
                  32'(vecs[i].exp_flag));
            run_op(1'b0, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].name);
        end

        // Single-chunk instance with flag in bit 0 only.
        run_op(1'b1, 2'b11, 16'h0005, 16'h0005, "b_sle_eq");
        run_op(1'b1, 2'b00, 16'h8000, 16'h7FFF, "b_slt_min");
        run_op(1'b1, 2'b01, 16'h8000, 16'h7FFF, "b_sltu");

        // Randomized ops on both instances.
        for (int i = 0; i < 60; i++) begin
            rop  = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 3);
            rx   = 16'($urandom);
            ry   = 16'($urandom);
            if (mode == 1) ry = rx;
            if (mode == 2) ry = rx ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
            if (mode == 3) begin
                rx = edge_vals[$urandom_range(0, 4)];
                ry = edge_vals[$urandom_range(0, 4)];
            end
            run_op(1'(i % 2), rop, rx, ry, "rand");
        end

        // start held high with operands changing during RUN; back-to-back accept in the done cycle.
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b01, 16'h0001, 16'h0002);
        @(posedge clk); #1;
        ndone = 0; dlat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
            @(posedge clk); #1;
            if (if_a.done) begin
                ndone++;
                dlat = i;
            end
        end
        check("held_start done_count", 32'(ndone), 32'd1);
        check("held_start latency", 32'(dlat), 32'd4);
        check("held_start flag", 32'(if_a.flag), 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b01, 16'hFFFF, 16'h0000);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        check("b2b accepted busy", 32'(if_a.busy), 32'd1);
        check("b2b done dropped", 32'(if_a.done), 32'd0);
        lat = 0;
        while (!if_a.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b latency", 32'(lat), 32'd4);
        check("b2b flag", 32'(if_a.flag), 32'd0);
        check("b2b result", 32'(if_a.result), 32'h0000);

        // Reset during the second RUN cycle aborts the operation.
        run_op(1'b0, 2'b00, 16'hFFFF, 16'h0001, "pre_abort");
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b00, 16'hFFFF, 16'h0001);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 16'hFFFF, 16'h0001);
        @(posedge clk); #1;
        check("abort busy_run2", 32'(if_a.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort busy",   32'(if_a.busy),   32'd0);
        check("abort done",   32'(if_a.done),   32'd0);
        check("abort flag",   32'(if_a.flag),   32'd0);
        check("abort result", 32'(if_a.result), 32'h0000);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (if_a.done) ndone++;
        end
        check("abort no_done", 32'(ndone), 32'd0);

        // Reset overrides start; the first edge after release accepts it.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b1, 2'b01, 16'h1230, 16'h1231);
        @(posedge clk); #1;
        check("rst_over_start busy", 32'(if_a.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        check("post_rst accept busy", 32'(if_a.busy), 32'd1);
        lat = 0;
        while (!if_a.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("post_rst latency", 32'(lat), 32'd4);
        check("post_rst flag", 32'(if_a.flag), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/compare_set_unit.md
COMPARE_SET_UNIT -- requirements
Module: compare_set_unit

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter CHUNK, default 4, bits compared per clock; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 Parameter MASK, default 1; 1 = flag replicated to all result bits, 0 = flag in result[0], upper bits zero.
REQ-004 clk  input  1  rising-edge clock, single clock domain.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request; sampled only while busy=0.
REQ-007 op  input  2  00 SLT signed x<y, 01 SLTU unsigned x<y, 10 SEQ x==y, 11 SLE signed x<=y.
REQ-008 x  input  WIDTH  first operand, sampled with start.
REQ-009 y  input  WIDTH  second operand, sampled with start.
REQ-010 busy  output  1  operation in progress.
REQ-011 done  output  1  one-cycle pulse: result and flag updated.
REQ-012 flag  output  1  comparison outcome, registered.
REQ-013 result  output  WIDTH  masked flag per MASK, registered.

Function
REQ-014 States SHALL be IDLE and RUN; busy=1 exactly when state=RUN.
REQ-015 IDLE and start=1 at an edge: latch x, y, op; load chunk counter with N; clear decided, lt, gt; go to RUN.
REQ-016 For signed ops (00, 11), the sign bit (MSB) of both latched operands SHALL be inverted at latch so that the unsigned compare yields the signed order; for 01 and 10 operands are latched unmodified.
REQ-017 Each RUN edge SHALL compare one CHUNK, MSB chunk first, then shift both operand registers left by CHUNK and decrement the counter.
REQ-018 If decided=0 and the chunks differ: set decided=1; set lt=1 if x chunk < y chunk, otherwise gt=1; once decided=1, later chunks SHALL NOT alter lt/gt.
REQ-019 At the RUN edge that processes the last chunk (counter=1): register flag per REQ-020, register result per REQ-021, assert done for the following cycle, return to IDLE.
REQ-020 flag = lt for 00/01; flag = ~lt & ~gt for 10; flag = ~gt for 11; the final chunk's outcome SHALL be included.
REQ-021 result = {WIDTH{flag}} when MASK=1; result = {{WIDTH-1{1'b0}}, flag} when MASK=0.
REQ-022 Latency: done=1 exactly N cycles after the edge accepting start; busy=1 for exactly those N cycles; fixed, data-independent (no early termination).
REQ-023 done SHALL be high for exactly one cycle per completed operation and low otherwise.
REQ-024 flag and result SHALL hold their last value until the next completion; they SHALL NOT change while busy=1.
REQ-025 start while busy=1 SHALL be ignored, with no queuing; latched operands SHALL be unaffected by input changes during RUN.
REQ-026 Back-to-back: start=1 in the done cycle (busy=0) SHALL be accepted, giving one operation every N+1 cycles at full rate.
REQ-027 CHUNK=WIDTH SHALL be legal: N=1, done one cycle after start.

Reset
REQ-028 rst=1 at an edge SHALL force state=IDLE, busy=0, done=0, flag=0, result=0, counter=0, decided=lt=gt=0, overriding start.
REQ-029 rst during RUN SHALL abort the operation; no done pulse SHALL follow for it.
REQ-030 The first edge with rst=0 and start=1 SHALL be accepted normally.

Verification (WIDTH=16, CHUNK=4, MASK=1 unless stated)
REQ-031 SLT x=0xFFFF, y=0x0001 -> busy high for 4 cycles, done 4 cycles after start, flag=1, result=0xFFFF; same with SLTU -> flag=0, result=0x0000.
REQ-032 x=y=0x8000: SEQ -> flag=1; SLE -> flag=1; SLT -> flag=0; SLT x=0x8000, y=0x7FFF -> flag=1; SLTU -> flag=0.
REQ-033 Difference only in LSB chunk: SLTU x=0x1230, y=0x1231 -> flag=1; difference in MSB chunk with contrary LSB: x=0x1FFF, y=0x2000 -> flag=1.
REQ-034 start held high with changing x/y during RUN -> first operands used, single done, new start accepted in the done cycle, next done 4 cycles later.
REQ-035 rst asserted at the 2nd RUN cycle -> next cycle busy=0, done=0, flag=0, result=0x0000, no later done.
REQ-036 MASK=0, CHUNK=16: SLE x=0x0005, y=0x0005 -> done 1 cycle after start, result=0x0001.
